// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin arbiter and issue sequencer for a
//                shared combinational ALU. Accepts one operation at a time,
//                issues it to the ALU, registers the result and returns it to
//                the originating requester over a response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int W    = 32,
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [OPW-1:0]  req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [OPW-1:0]  req1_op,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [W-1:0]    rsp0_data,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [W-1:0]    rsp1_data,

    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [W-1:0]    alu_out,

    output logic            busy,
    output logic [CNTW-1:0] done_cnt
);

    localparam logic [CNTW-1:0] C_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [OPW-1:0]  r_op;
    logic [W-1:0]    r_res;
    logic            r_id;
    logic            r_last;
    logic            r_busy;
    logic [CNTW-1:0] r_done_cnt;

    logic            w_idle;
    logic            w_gnt_id;
    logic            w_accept;
    logic            w_owner_ready;
    logic            w_rsp_done;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    // Readies are gated with rst_n so they read 0 while reset is held.
    assign w_idle        = (r_state == ST_IDLE) && rst_n;
    assign req0_ready    = w_idle && req0_valid && !w_gnt_id;
    assign req1_ready    = w_idle && req1_valid &&  w_gnt_id;
    assign w_accept      = req0_ready || req1_ready;
    assign w_owner_ready = r_id ? rsp1_ready : rsp0_ready;
    assign w_rsp_done    = (r_state == ST_RESP) && w_owner_ready;

    // Next-state logic for the IDLE -> ISSUE -> RESP operation cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_state_nxt = ST_ISSUE;
            ST_ISSUE:                 w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; busy is registered so it tracks ISSUE/RESP glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Latch the granted operation on the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_a  <= w_gnt_id ? req1_a  : req0_a;
            r_b  <= w_gnt_id ? req1_b  : req0_b;
            r_op <= w_gnt_id ? req1_op : req0_op;
            r_id <= w_gnt_id;
        end
    end

    // Capture the ALU result at the end of the single ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_res <= alu_out;
        end
    end

    // Completion bookkeeping: remember who was served and count responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_done_cnt <= '0;
        end else if (w_rsp_done) begin
            r_last     <= r_id;
            r_done_cnt <= r_done_cnt + C_CNT_ONE;
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;

    assign rsp0_valid = (r_state == ST_RESP) && !r_id;
    assign rsp1_valid = (r_state == ST_RESP) &&  r_id;
    assign rsp0_data  = r_res;
    assign rsp1_data  = r_res;

    assign busy       = r_busy;
    assign done_cnt   = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with an adder stub ALU
//                and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W    = 32;
    localparam int OPW  = 5;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready, rsp1_ready;
    logic [W-1:0]    rsp0_data, rsp1_data;
    logic [W-1:0]    alu_a, alu_b, alu_out;
    logic [OPW-1:0]  alu_op;
    logic            busy;
    logic [CNTW-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Stub ALU: plain adder.
    assign alu_out = alu_a + alu_b;

    // ---------------- transaction-level reference model ----------------
    bit             m_inflight;   // an operation is owned by the arbiter
    int             m_age;        // edges since accept (0 = being issued)
    int             m_owner;
    int             m_last;
    int             m_cnt;
    logic [W-1:0]   m_a, m_b, m_res, m_shown;
    logic [OPW-1:0] m_op;

    function automatic void mdl_reset();
        m_inflight = 0; m_age = 0; m_owner = 0; m_last = 1; m_cnt = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_shown = '0;
    endfunction

    function automatic bit exp_ready(int n);
        if (m_inflight || !rst_n) return 1'b0;
        if (n == 0) return req0_valid && (!req1_valid || m_last == 1);
        return req1_valid && (!req0_valid || m_last == 0);
    endfunction

    function automatic void mdl_accept(int n, logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
        m_inflight = 1; m_age = 0; m_owner = n;
        m_a = a; m_b = b; m_op = op; m_res = a + b;
    endfunction

    function automatic void mdl_edge();
        if (!rst_n) begin
            mdl_reset();
        end else if (!m_inflight) begin
            if (exp_ready(0))      mdl_accept(0, req0_a, req0_b, req0_op);
            else if (exp_ready(1)) mdl_accept(1, req1_a, req1_b, req1_op);
        end else if (m_age == 0) begin
            m_shown = m_res;
            m_age   = 1;
        end else if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) begin
            m_cnt      = (m_cnt + 1) % (1 << CNTW);
            m_last     = m_owner;
            m_inflight = 0;
        end
    endfunction

    // One clock: model follows the edge, then return at the falling edge.
    task automatic advance();
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        mdl_reset();
        req0_valid = 1;
        @(negedge clk); #1;
        checks++;
        if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_reset got=%b exp=0", req0_ready); end
        req0_valid = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== '0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
        checks++;
        if (done_cnt !== '0 || rsp0_data !== '0 || rsp1_data !== '0) begin
            failures++; $display("FAIL reset_data got cnt=%0d d0=%h d1=%h exp=0", done_cnt, rsp0_data, rsp1_data);
        end
    endtask

    task automatic test_single();
        req0_valid = 1; req0_a = 3; req0_b = 2; req0_op = 0; rsp0_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL single_accept got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        advance();
        req0_valid = 0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b1 || rsp1_valid !== 1'b0) begin
            failures++; $display("FAIL single_issue got v0=%b busy=%b v1=%b exp 0/1/0", rsp0_valid, busy, rsp1_valid);
        end
        advance(); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd5 || rsp1_valid !== 1'b0) begin
            failures++; $display("FAIL single_resp got v0=%b d=%0d v1=%b exp v0=1 d=5 v1=0", rsp0_valid, rsp0_data, rsp1_valid);
        end
        advance(); #1;
        checks++;
        if (done_cnt !== 2'd1 || rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_done got cnt=%0d v0=%b busy=%b exp 1/0/0", done_cnt, rsp0_valid, busy);
        end
        rsp0_ready = 0;
    endtask

    task automatic test_tie();
        int             g_id[$];
        int             g_cyc[$];
        logic [W-1:0]   rsp_q[$];
        int             exp_id [4] = '{0, 1, 0, 1};
        logic [W-1:0]   exp_rsp[4] = '{32'd2, 32'd30, 32'd2, 32'd30};
        req0_valid = 1; req0_a = 1;  req0_b = 1;  req0_op = 0;
        req1_valid = 1; req1_a = 10; req1_b = 20; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
            if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
            if (rsp0_valid) rsp_q.push_back(rsp0_data);
            if (rsp1_valid) rsp_q.push_back(rsp1_data);
            advance();
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (g_id.size() != 4 || rsp_q.size() != 4) begin
            failures++; $display("FAIL tie_counts got grants=%0d rsps=%0d exp 4/4", g_id.size(), rsp_q.size());
        end
        for (int k = 0; k < 4 && k < g_id.size() && k < rsp_q.size(); k++) begin
            checks++;
            if (g_id[k] != exp_id[k] || g_cyc[k] != 3 * k || rsp_q[k] !== exp_rsp[k]) begin
                failures++;
                $display("FAIL tie_seq[%0d] got id=%0d cyc=%0d rsp=%0d exp id=%0d cyc=%0d rsp=%0d",
                         k, g_id[k], g_cyc[k], rsp_q[k], exp_id[k], 3 * k, exp_rsp[k]);
            end
        end
        #1;
        checks++;
        if (done_cnt !== 2'd0) begin failures++; $display("FAIL tie_cnt_wrap got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_backpressure();
        req1_valid = 1; req1_a = 7; req1_b = 8; req1_op = 5'd3;
        rsp1_ready = 0; rsp0_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1 got=%b exp=1", req1_ready); end
        advance();
        req1_valid = 0;
        req0_valid = 1; req0_a = 4; req0_b = 5; req0_op = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_issue_stall got=%b exp=0", req0_ready); end
        advance();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd15 || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v1=%b d1=%0d r0=%b v0=%b exp 1/15/0/0", k, rsp1_valid, rsp1_data, req0_ready, rsp0_valid);
            end
            advance();
        end
        rsp1_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || rsp1_valid !== 1'b1) begin
            failures++; $display("FAIL bp_same_cycle got r0=%b v1=%b exp r0=0 v1=1", req0_ready, rsp1_valid);
        end
        advance();
        rsp1_ready = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || done_cnt !== 2'd1) begin
            failures++; $display("FAIL bp_req0_next got r0=%b cnt=%0d exp r0=1 cnt=1", req0_ready, done_cnt);
        end
        advance();
        req0_valid = 0; rsp0_ready = 0; rsp1_ready = 1;
        advance();
        // Owner is requester 0; only the other requester is ready.
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd9 || done_cnt !== 2'd1) begin
                failures++;
                $display("FAIL nonowner_hold[%0d] got v0=%b d0=%0d cnt=%0d exp 1/9/1", k, rsp0_valid, rsp0_data, done_cnt);
            end
            advance();
        end
        rsp0_ready = 1;
        advance(); #1;
        checks++;
        if (done_cnt !== 2'd2 || rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL nonowner_done got cnt=%0d v0=%b busy=%b exp 2/0/0", done_cnt, rsp0_valid, busy);
        end
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_reset_midop();
        req0_valid = 1; req0_a = 1;  req0_b = 1;
        req1_valid = 1; req1_a = 10; req1_b = 20;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++; $display("FAIL midop_rr got r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
        end
        advance();
        // In ISSUE now: assert reset between edges.
        rst_n = 0;
        mdl_reset();
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 || {alu_a, alu_b, alu_op} !== '0 ||
            done_cnt !== '0 || rsp1_data !== '0) begin
            failures++;
            $display("FAIL midop_async got ctrl=%b alu_a=%h cnt=%0d d1=%h exp all 0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, alu_a, done_cnt, rsp1_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL midop_tie_after got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            advance(); #1;
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL midop_no_rsp[%0d] got v0=%b v1=%b busy=%b exp 0/0/0", k, rsp0_valid, rsp1_valid, busy);
            end
        end
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_wrap();
        logic [CNTW-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        rsp0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1; req0_a = W'(i); req0_b = 1; req0_op = 0;
            advance();
            req0_valid = 0;
            advance();
            advance();
            #1;
            checks++;
            if (done_cnt !== exp_cnt[i]) begin
                failures++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, done_cnt, exp_cnt[i]);
            end
        end
        rsp0_ready = 0;
    endtask

    task automatic test_random(int n);
        bit acc0 = 0, acc1 = 0;
        bit e_r0, e_r1, e_v0, e_v1;
        for (int i = 0; i < n; i++) begin
            // Requesters hold valid and operands until their request is taken.
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = $urandom; req0_b = $urandom; req0_op = OPW'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = $urandom; req1_b = $urandom; req1_op = OPW'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r0 = exp_ready(0);
            e_r1 = exp_ready(1);
            e_v0 = m_inflight && m_age >= 1 && m_owner == 0;
            e_v1 = m_inflight && m_age >= 1 && m_owner == 1;
            checks++;
            if (req0_ready !== e_r0) begin failures++; $display("FAIL rnd_req0_ready cyc=%0d got=%b exp=%b", i, req0_ready, e_r0); end
            checks++;
            if (req1_ready !== e_r1) begin failures++; $display("FAIL rnd_req1_ready cyc=%0d got=%b exp=%b", i, req1_ready, e_r1); end
            checks++;
            if (rsp0_valid !== e_v0) begin failures++; $display("FAIL rnd_rsp0_valid cyc=%0d got=%b exp=%b", i, rsp0_valid, e_v0); end
            checks++;
            if (rsp1_valid !== e_v1) begin failures++; $display("FAIL rnd_rsp1_valid cyc=%0d got=%b exp=%b", i, rsp1_valid, e_v1); end
            checks++;
            if (rsp0_data !== m_shown || rsp1_data !== m_shown) begin
                failures++; $display("FAIL rnd_rsp_data cyc=%0d got=%h/%h exp=%h", i, rsp0_data, rsp1_data, m_shown);
            end
            checks++;
            if (busy !== m_inflight) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_inflight); end
            checks++;
            if (done_cnt !== CNTW'(m_cnt)) begin failures++; $display("FAIL rnd_done_cnt cyc=%0d got=%0d exp=%0d", i, done_cnt, m_cnt); end
            checks++;
            if (alu_a !== m_a || alu_b !== m_b || alu_op !== m_op) begin
                failures++; $display("FAIL rnd_alu cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, alu_a, alu_b, alu_op, m_a, m_b, m_op);
            end
            acc0 = e_r0;
            acc1 = e_r1;
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_tie();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        do_reset();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
